// File: rtl/io_pkg.sv
// io_pkg: shared sizes and debounce timing for the switch/button input conditioner
package io_pkg;
   localparam int SWITCH_WIDTH          = 16;
   localparam int DEBOUNCE_TICK_DIV     = 100000;
   localparam int DEBOUNCE_STABLE_TICKS = 5;
   localparam int BTN_CH                = SWITCH_WIDTH;
   function automatic int cnt_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/io_switch_conditioner_if.sv
// io_switch_conditioner_if: raw board inputs and conditioned switch/button outputs
interface io_switch_conditioner_if import io_pkg::*; #(parameter int WIDTH = SWITCH_WIDTH) ();
   logic [WIDTH-1:0] sw_raw;
   logic             btn_raw;
   logic [WIDTH-1:0] io_rdata_switch;
   logic             sw_changed;
   logic             btn_level;
   logic             btn_press;
   modport master (output sw_raw, btn_raw, input io_rdata_switch, sw_changed, btn_level, btn_press);
   modport slave  (input sw_raw, btn_raw, output io_rdata_switch, sw_changed, btn_level, btn_press);
endinterface

// File: rtl/io_switch_conditioner_debounce_bit.sv
// debounce_bit: two-flop synchroniser plus tick-sampled persistence filter for one channel
module debounce_bit import io_pkg::*; #(
   parameter int STABLE_TICKS = DEBOUNCE_STABLE_TICKS
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic raw,
   output logic stable
);
   localparam int CW = $clog2(STABLE_TICKS + 1);
   localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);
   logic          sync1_q, sync1_d, sync2_q, sync2_d, stable_q, stable_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          differ, done;
   always_comb begin
      sync1_d  = raw;
      sync2_d  = sync1_q;
      differ   = sync2_q != stable_q;
      done     = cnt_q == LAST;
      stable_d = (tick && differ && done) ? sync2_q : stable_q;
      // any tick that agrees with the stable level restarts the persistence count
      cnt_d    = !tick ? cnt_q : (differ && !done) ? cnt_q + 1'b1 : '0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end
   assign stable = stable_q;
endmodule

// File: rtl/io_switch_conditioner.sv
// io_switch_conditioner: synchronised, debounced switches and confirm button with change/press pulses
module io_switch_conditioner import io_pkg::*; #(
   parameter int WIDTH        = SWITCH_WIDTH,
   parameter int TICK_DIV     = DEBOUNCE_TICK_DIV,
   parameter int STABLE_TICKS = DEBOUNCE_STABLE_TICKS
) (
   input logic                     clk,
   input logic                     rst,
   io_switch_conditioner_if.slave  bus
);
   localparam int PW = cnt_w(TICK_DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
   logic [PW-1:0]    pre_q, pre_d;
   logic             tick;
   logic [WIDTH:0]   raw, stable;
   logic [WIDTH-1:0] sw_q, sw_d;
   logic             chg_q, chg_d, btn_q, btn_d, prs_q, prs_d;
   assign raw = {bus.btn_raw, bus.sw_raw};
   genvar g;
   for (g = 0; g <= WIDTH; g++) begin : g_ch
      debounce_bit #(.STABLE_TICKS(STABLE_TICKS)) u_db (
         .clk    (clk),
         .rst    (rst),
         .tick   (tick),
         .raw    (raw[g]),
         .stable (stable[g])
      );
   end
   always_comb begin
      tick  = pre_q == PRE_LAST;
      pre_d = tick ? '0 : pre_q + 1'b1;
      sw_d  = stable[WIDTH-1:0];
      chg_d = sw_d != sw_q;
      btn_d = stable[WIDTH];
      prs_d = btn_d && !btn_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q <= '0;
         sw_q  <= '0;
         chg_q <= 1'b0;
         btn_q <= 1'b0;
         prs_q <= 1'b0;
      end else begin
         pre_q <= pre_d;
         sw_q  <= sw_d;
         chg_q <= chg_d;
         btn_q <= btn_d;
         prs_q <= prs_d;
      end
   end
   assign bus.io_rdata_switch = sw_q;
   assign bus.sw_changed      = chg_q;
   assign bus.btn_level       = btn_q;
   assign bus.btn_press       = prs_q;
endmodule

// File: tb/tb_io_switch_conditioner.sv
// tb_io_switch_conditioner: directed and random checks against a tick-window reference model
module tb_io_switch_conditioner;
   import io_pkg::*;
   localparam int W = 16, TD = 4, ST = 3;
   logic clk = 1'b0, rst = 1'b1, rst1 = 1'b1;
   always #5 clk = ~clk;
   io_switch_conditioner_if #(.WIDTH(W)) bus ();
   io_switch_conditioner_if #(.WIDTH(W)) bus1 ();
   io_switch_conditioner #(.WIDTH(W), .TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
      .clk (clk), .rst (rst), .bus (bus.slave));
   io_switch_conditioner #(.WIDTH(W), .TICK_DIV(1), .STABLE_TICKS(ST)) dut1 (
      .clk (clk), .rst (rst1), .bus (bus1.slave));
   int passed = 0, total = 0, n_chg = 0, n_prs = 0;
   logic [W-1:0] exp_sw;
   logic exp_chg, exp_btn, exp_prs;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         step(1);
         n_chg += int'(bus.sw_changed);
         n_prs += int'(bus.btn_press);
      end
   endtask

   task automatic reset_main();
      rst = 1'b1;
      bus.sw_raw = '0;
      bus.btn_raw = 1'b0;
      step(2);
      rst = 1'b0;
      step(1);
      n_chg = 0;
      n_prs = 0;
   endtask

   // Model: a bit accepts a new level once the last ST tick samples of its
   // synchronised input all disagree with its current stable level.
   initial begin
      logic [W:0] stable, s;
      logic [W:0] raw_hist[$];
      logic [W:0] tick_hist[$];
      int cyc, n;
      forever begin
         @(posedge clk);
         if (rst) begin
            stable = '0;
            raw_hist = '{'0, '0};
            tick_hist.delete();
            cyc = 0;
            exp_sw = '0; exp_chg = 1'b0; exp_btn = 1'b0; exp_prs = 1'b0;
         end else begin
            exp_chg = stable[W-1:0] != exp_sw;
            exp_prs = stable[W] && !exp_btn;
            exp_sw  = stable[W-1:0];
            exp_btn = stable[W];
            s = raw_hist.pop_front();
            raw_hist.push_back({bus.btn_raw, bus.sw_raw});
            if (cyc % TD == TD - 1) begin
               tick_hist.push_back(s);
               if (tick_hist.size() > ST) void'(tick_hist.pop_front());
               for (int b = 0; b <= W; b++) begin
                  n = 0;
                  foreach (tick_hist[k]) if (tick_hist[k][b] != stable[b]) n++;
                  if (n == ST) stable[b] = ~stable[b];
               end
            end
            cyc++;
         end
         #1;
         check("m_sw",  bus.io_rdata_switch, exp_sw);
         check("m_chg", bus.sw_changed, exp_chg);
         check("m_btn", bus.btn_level, exp_btn);
         check("m_prs", bus.btn_press, exp_prs);
      end
   end

   initial begin
      bus.sw_raw = 16'hFFFF;
      bus.btn_raw = 1'b1;
      bus1.sw_raw = '0;
      bus1.btn_raw = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(1);
         check("rst_sw", bus.io_rdata_switch, 16'h0);
         check("rst_btn", {bus.sw_changed, bus.btn_level, bus.btn_press}, 3'b000);
      end
      rst = 1'b0;
      bus.sw_raw = '0;
      bus.btn_raw = 1'b0;
      step(1);
      check("post_rst_sw", bus.io_rdata_switch, 16'h0);
      check("post_rst_btn", {bus.sw_changed, bus.btn_level, bus.btn_press}, 3'b000);
      // clean change, exact latency
      n_chg = 0; n_prs = 0;
      bus.sw_raw = 16'h00A5;
      run(11);
      check("clean_before", bus.io_rdata_switch, 16'h0);
      step(1);
      check("clean_sw", bus.io_rdata_switch, 16'h00A5);
      check("clean_chg", bus.sw_changed, 1'b1);
      check("model_pin_sw", exp_sw, 16'h00A5);
      n_chg = 1;
      run(3);
      check("clean_one_pulse", n_chg, 1);
      check("clean_no_press", n_prs, 0);
      // glitch
      reset_main();
      bus.sw_raw = 16'h0001;
      run(6);
      bus.sw_raw = 16'h0000;
      run(30);
      check("glitch_sw", bus.io_rdata_switch, 16'h0);
      check("glitch_chg", n_chg, 0);
      // bounce
      reset_main();
      for (int i = 0; i < 12; i++) begin
         bus.btn_raw = ~bus.btn_raw;
         run(2);
      end
      bus.btn_raw = 1'b1;
      run(30);
      check("bounce_level", bus.btn_level, 1'b1);
      check("bounce_press", n_prs, 1);
      bus.btn_raw = 1'b0;
      run(30);
      check("release_level", bus.btn_level, 1'b0);
      check("release_press", n_prs, 1);
      // simultaneous bits
      reset_main();
      bus.sw_raw = 16'h8001;
      run(25);
      check("simul_sw", bus.io_rdata_switch, 16'h8001);
      check("simul_chg", n_chg, 1);
      // reset mid-debounce
      reset_main();
      bus.sw_raw = 16'h0008;
      step(7);
      rst = 1'b1;
      step(1);
      check("middeb_rst", bus.io_rdata_switch, 16'h0);
      rst = 1'b0;
      step(12);
      check("middeb_before", bus.io_rdata_switch, 16'h0);
      step(1);
      check("middeb_sw", bus.io_rdata_switch, 16'h0008);
      check("middeb_chg", bus.sw_changed, 1'b1);
      // TICK_DIV=1: exactly 3+ST cycles
      rst1 = 1'b0;
      step(2);
      bus1.sw_raw = 16'h0040;
      step(5);
      check("td1_before", bus1.io_rdata_switch, 16'h0);
      step(1);
      check("td1_sw", bus1.io_rdata_switch, 16'h0040);
      check("td1_chg", bus1.sw_changed, 1'b1);
      step(1);
      check("td1_chg_low", bus1.sw_changed, 1'b0);
      bus1.btn_raw = 1'b1;
      step(5);
      check("td1_btn_before", bus1.btn_level, 1'b0);
      step(1);
      check("td1_btn", {bus1.btn_level, bus1.btn_press}, 2'b11);
      step(1);
      check("td1_prs_low", bus1.btn_press, 1'b0);
      bus1.btn_raw = 1'b0;
      step(6);
      check("td1_release", {bus1.btn_level, bus1.btn_press}, 2'b00);
      // random traffic against the model
      reset_main();
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 24) == 0) begin
            rst = 1'b1;
            step(1);
            rst = 1'b0;
         end
         bus.sw_raw = bus.sw_raw ^ (16'($urandom()) & 16'($urandom()));
         if ($urandom_range(0, 2) == 0) bus.btn_raw = ~bus.btn_raw;
         step($urandom_range(1, 24));
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
